// File: rtl/apb_mailbox.sv
// apb_mailbox: APB slave exposing a TX FIFO (APB push, stream pop) and an
// RX FIFO (stream push, APB pop), with blocking accesses that stall on a
// full TX / empty RX FIFO and give up with an error after TIMEOUT cycles.
// Optional feature: define APB_MAILBOX_IRQ_EN to build the CTRL.irq_en flop
// and the registered interrupt; otherwise irq_o is tied low.
module apb_mailbox #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        tx_valid_o,
    output logic [31:0] tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [31:0] rx_data_i,
    output logic        rx_ready_o,
    output logic        irq_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    // Number of wait states after which a stalled access is abandoned.
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;

    logic [31:0]         r_tx_mem [DEPTH];
    logic [PTR_W-1:0]    r_tx_wptr;
    logic [PTR_W-1:0]    r_tx_rptr;
    logic [CNT_W-1:0]    r_tx_cnt;

    logic [31:0]         r_rx_mem [DEPTH];
    logic [PTR_W-1:0]    r_rx_wptr;
    logic [PTR_W-1:0]    r_rx_rptr;
    logic [CNT_W-1:0]    r_rx_cnt;

    logic                r_err;
    logic                w_irq_en;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic       w_access;
    logic [1:0] w_reg;
    logic       w_bad_addr;
    logic       w_err_acc;
    logic       w_tx_wr;
    logic       w_rx_rd;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_block;
    logic       w_ready;
    logic       w_slverr;
    logic       w_done_ok;

    // Reset masks the access so nothing completes while rst_n is low.
    assign w_access   = rst_n & PSEL & PENABLE;
    assign w_reg      = PADDR[3:2];
    assign w_bad_addr = (PADDR[11:4] != 8'd0) | (PADDR[1:0] != 2'd0);

    assign w_err_acc  = w_bad_addr
                      | ((w_reg == REG_RXDATA) &  PWRITE)
                      | ((w_reg == REG_TXDATA) & !PWRITE)
                      | ((w_reg == REG_TXDATA) &  PWRITE & (PSTRB != 4'hF));

    assign w_tx_wr    = !w_err_acc & (w_reg == REG_TXDATA);
    assign w_rx_rd    = !w_err_acc & (w_reg == REG_RXDATA);

    // Full/empty always come from the start-of-cycle counts.
    assign w_tx_full  = (r_tx_cnt == CNT_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CNT_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);

    assign w_block    = (w_tx_wr & w_tx_full) | (w_rx_rd & w_rx_empty);

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    // State and wait-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Next state, completion and error; the wait counter holds the number of
    // wait states already spent on the current access and is zero otherwise.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_ready     = 1'b0;
        w_slverr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wcnt_nxt = '0;
                if (w_access) begin
                    if (w_err_acc) begin
                        w_ready  = 1'b1;
                        w_slverr = 1'b1;
                    end else if (w_block) begin
                        w_state_nxt = S_STALL;
                        w_wcnt_nxt  = WCNT_ONE;
                    end else begin
                        w_ready = 1'b1;
                    end
                end
            end
            S_STALL: begin
                if (!w_access) begin
                    // Master walked away: drop the access without side effects.
                    w_state_nxt = S_IDLE;
                    w_wcnt_nxt  = '0;
                end else if (w_err_acc) begin
                    w_ready     = 1'b1;
                    w_slverr    = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_wcnt_nxt  = '0;
                end else if (!w_block) begin
                    w_ready     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_wcnt_nxt  = '0;
                end else if (r_wcnt >= WCNT_LAST) begin
                    w_ready     = 1'b1;
                    w_slverr    = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_wcnt_nxt = r_wcnt + WCNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    assign PREADY    = w_ready;
    assign PSLVERR   = w_slverr;
    assign w_done_ok = w_ready & !w_slverr;

    // ------------------------------------------------------------------
    // Register side effects
    // ------------------------------------------------------------------
    logic w_ctrl_wr;
    logic w_stat_wr;
    logic w_tx_flush;
    logic w_rx_flush;

    assign w_ctrl_wr  = w_done_ok & PWRITE & (w_reg == REG_CTRL) & PSTRB[0];
    assign w_stat_wr  = w_done_ok & PWRITE & (w_reg == REG_STATUS) & PSTRB[2];
    assign w_tx_flush = w_ctrl_wr & PWDATA[1];
    assign w_rx_flush = w_ctrl_wr & PWDATA[2];

    // ------------------------------------------------------------------
    // TX FIFO: pushed by APB, popped by the stream consumer
    // ------------------------------------------------------------------
    logic w_tx_push;
    logic w_tx_pop;

    assign w_tx_push  = w_done_ok & w_tx_wr & !w_tx_full;
    assign w_tx_pop   = !w_tx_empty & tx_ready_i;
    assign tx_valid_o = !w_tx_empty;
    assign tx_data_o  = r_tx_mem[r_tx_rptr];

    // TX pointers and count; a flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else if (w_tx_flush) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CNT_ONE;
                2'b01:   r_tx_cnt <= r_tx_cnt - CNT_ONE;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // TX storage write (not reset).
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= PWDATA;
    end

    // ------------------------------------------------------------------
    // RX FIFO: pushed by the stream producer, popped by APB
    // ------------------------------------------------------------------
    logic w_rx_push;
    logic w_rx_pop;

    assign rx_ready_o = !w_rx_full;
    assign w_rx_push  = rx_valid_i & !w_rx_full;
    assign w_rx_pop   = w_done_ok & w_rx_rd & !w_rx_empty;

    // RX pointers and count; a flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else if (w_rx_flush) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CNT_ONE;
                2'b01:   r_rx_cnt <= r_rx_cnt - CNT_ONE;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // RX storage write (not reset).
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data_i;
    end

    // ------------------------------------------------------------------
    // Sticky error flag
    // ------------------------------------------------------------------
    // Set by any error completion, cleared by writing 1 to STATUS bit 18.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_ready & w_slverr) begin
            r_err <= 1'b1;
        end else if (w_stat_wr & PWDATA[18]) begin
            r_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
`ifdef APB_MAILBOX_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // CTRL.irq_en register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_irq_en <= PWDATA[0];
        end
    end

    // Registered interrupt: pending RX data or a sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en & (!w_rx_empty | r_err);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq_o    = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq_o    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [7:0] w_tx_cnt8;
    logic [7:0] w_rx_cnt8;

    assign w_tx_cnt8 = 8'(r_tx_cnt);
    assign w_rx_cnt8 = 8'(r_rx_cnt);

    // Read mux; zero unless a read completes without error.
    always_comb begin
        PRDATA = 32'd0;
        if (w_done_ok & !PWRITE) begin
            case (w_reg)
                REG_RXDATA: PRDATA = r_rx_mem[r_rx_rptr];
                REG_STATUS: PRDATA = {13'd0, r_err, w_rx_empty, w_tx_full,
                                      w_rx_cnt8, w_tx_cnt8};
                REG_CTRL:   PRDATA = {31'd0, w_irq_en};
                default:    PRDATA = 32'd0;
            endcase
        end
    end

endmodule
